bcd_count_ctrl: RTL and testbench

Run controller for the two-digit BCD 00–99 counter. Sequences the counter through idle, run, pause and done states from start/stop/clear/load commands. Paces counting with an internal prescaler, supports up or down direction, and stops at a programmable BCD limit. It sits between front-panel or bus command logic and the digit display/decoder path; the counter itself is instantiated inside.

---
 rtl/bcd_count_pkg.sv | 26 ++
 rtl/bcd2_updown.sv | 76 +++++++
 rtl/bcd_count_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bcd_count_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bcd_count_pkg.sv
//------------------------------------------------------------------------------
// Module  : bcd_count_pkg
// Purpose : Shared state encoding, BCD constants and helpers for the BCD counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bcd_count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Presets arrive from front-panel/bus logic and may be out of BCD range.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_updown.sv
//------------------------------------------------------------------------------
// Module  : bcd2_updown
// Purpose : Two-digit BCD up/down counter (00-99) with synchronous load.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd2_updown
    import bcd_count_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       ld,
    input  logic [3:0] ld_ones,
    input  logic [3:0] ld_tens,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] nxt_ones,
    output logic [3:0] nxt_tens
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    // Stepped value is exported so the controller can compare it to the limit
    // and flag DONE on the same edge the value lands.
    always_comb begin
        nxt_ones = ones_q;
        nxt_tens = tens_q;
        if (dir) begin
            if (ones_q >= BCD_MAX) begin
                nxt_ones = 4'd0;
                nxt_tens = (tens_q >= BCD_MAX) ? 4'd0 : tens_q + 4'd1;
            end else begin
                nxt_ones = ones_q + 4'd1;
            end
        end else begin
            if (ones_q == 4'd0) begin
                nxt_ones = BCD_MAX;
                nxt_tens = (tens_q == 4'd0) ? BCD_MAX : tens_q - 4'd1;
            end else begin
                nxt_ones = ones_q - 4'd1;
            end
        end
    end

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (ld) begin
            ones_d = ld_ones;
            tens_d = ld_tens;
        end else if (en) begin
            ones_d = nxt_ones;
            tens_d = nxt_tens;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;

endmodule

`default_nettype wire

// File: rtl/bcd_count_ctrl.sv
//------------------------------------------------------------------------------
// Module  : bcd_count_ctrl
// Purpose : Run controller (IDLE/RUN/PAUSE/DONE) with prescaler and BCD limit
//           around a two-digit BCD counter. Optional lap capture: BCD_COUNT_CTRL_LAP_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_count_ctrl
    import bcd_count_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    input  logic [3:0] lim_ones,
    input  logic [3:0] lim_tens,
    input  logic       dir,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       done,
    output logic       step
`ifdef BCD_COUNT_CTRL_LAP_EN
    ,
    input  logic       lap,
    output logic [3:0] lap_ones,
    output logic [3:0] lap_tens
`endif
);

    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

    ctrl_state_t   state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          step_q, step_d;

    logic          cnt_en;
    logic          cnt_ld;
    logic [3:0]    cnt_ld_ones;
    logic [3:0]    cnt_ld_tens;
    logic [3:0]    nxt_ones;
    logic [3:0]    nxt_tens;
    logic          at_lim;

    bcd2_updown u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .dir      (dir),
        .ld       (cnt_ld),
        .ld_ones  (cnt_ld_ones),
        .ld_tens  (cnt_ld_tens),
        .ones     (ones),
        .tens     (tens),
        .nxt_ones (nxt_ones),
        .nxt_tens (nxt_tens)
    );

    assign at_lim = (nxt_ones == lim_ones) && (nxt_tens == lim_tens);

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        step_d      = 1'b0;
        cnt_en      = 1'b0;
        cnt_ld      = 1'b0;
        cnt_ld_ones = 4'd0;
        cnt_ld_tens = 4'd0;

        if (clear) begin
            cnt_ld  = 1'b1;
            pre_d   = '0;
            state_d = IDLE;
        end else if (load) begin
            cnt_ld      = 1'b1;
            cnt_ld_ones = bcd_clamp(load_ones);
            cnt_ld_tens = bcd_clamp(load_tens);
            pre_d       = '0;
            state_d     = IDLE;
        end else if (stop && state_q == RUN) begin
            state_d = PAUSE;
        end else if (start && state_q != RUN) begin
            state_d = RUN;
            if (state_q == IDLE) begin
                pre_d = '0;
            end else if (state_q == DONE) begin
                cnt_ld      = 1'b1;
                cnt_ld_ones = dir ? 4'd0 : BCD_MAX;
                cnt_ld_tens = dir ? 4'd0 : BCD_MAX;
                pre_d       = '0;
            end
        end else if (state_q == RUN) begin
            // Only a step landing on the limit ends the run.
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                cnt_en = 1'b1;
                step_d = 1'b1;
                if (at_lim) begin
                    state_d = DONE;
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            step_q  <= step_d;
        end
    end

    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign step    = step_q;

`ifdef BCD_COUNT_CTRL_LAP_EN
    logic [3:0] lap_ones_q, lap_ones_d;
    logic [3:0] lap_tens_q, lap_tens_d;

    // Captures the registered (pre-step) count even on a step edge.
    always_comb begin
        lap_ones_d = lap_ones_q;
        lap_tens_d = lap_tens_q;
        if (clear) begin
            lap_ones_d = 4'd0;
            lap_tens_d = 4'd0;
        end else if (lap && (state_q == RUN || state_q == PAUSE)) begin
            lap_ones_d = ones;
            lap_tens_d = tens;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_ones_q <= 4'd0;
            lap_tens_q <= 4'd0;
        end else begin
            lap_ones_q <= lap_ones_d;
            lap_tens_q <= lap_tens_d;
        end
    end

    assign lap_ones = lap_ones_q;
    assign lap_tens = lap_tens_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_count_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_bcd_count_ctrl
// Purpose : Directed self-checking bench for bcd_count_ctrl (DIV=4 and DIV=1).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_count_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, clear, load, dir;
    logic [3:0] load_ones, load_tens, lim_ones, lim_tens;

    logic [3:0] ones4, tens4, ones1, tens1;
    logic       running4, done4, step4, running1, done1, step1;
`ifdef BCD_COUNT_CTRL_LAP_EN
    logic       lap;
    logic [3:0] lap_ones4, lap_tens4, lap_ones1, lap_tens1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_count_ctrl #(.DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_ones(load_ones), .load_tens(load_tens), .lim_ones(lim_ones), .lim_tens(lim_tens),
        .dir(dir), .ones(ones4), .tens(tens4), .running(running4), .done(done4), .step(step4)
`ifdef BCD_COUNT_CTRL_LAP_EN
        , .lap(lap), .lap_ones(lap_ones4), .lap_tens(lap_tens4)
`endif
    );

    bcd_count_ctrl #(.DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_ones(load_ones), .load_tens(load_tens), .lim_ones(lim_ones), .lim_tens(lim_tens),
        .dir(dir), .ones(ones1), .tens(tens1), .running(running1), .done(done1), .step(step1)
`ifdef BCD_COUNT_CTRL_LAP_EN
        , .lap(lap), .lap_ones(lap_ones1), .lap_tens(lap_tens1)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load_tens = t; load_ones = o; load = 1'b1; tick(); load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; dir = 1'b1;
        load_ones = 4'd0; load_tens = 4'd0; lim_ones = 4'd9; lim_tens = 4'd9;
`ifdef BCD_COUNT_CTRL_LAP_EN
        lap = 1'b0;
`endif
        tick(2);
        rst = 1'b0;
        chk("rst_count", {tens4, ones4}, 8'h00);
        chk("rst_flags", {5'd0, running4, done4, step4}, 8'h00);

        // DIV=4 first steps
        start = 1'b1; tick(); start = 1'b0;
        chk("d4_running", {7'd0, running4}, 8'h01);
        tick(3);
        chk("d4_pre_step", {step4, 3'd0, ones4}, 8'h00);
        tick();
        chk("d4_step1", {step4, 3'd0, ones4}, 8'h81);
        tick();
        chk("d4_step_pulse", {7'd0, step4}, 8'h00);
        tick(3);
        chk("d4_step2", {tens4, ones4}, 8'h02);

        // DIV=1 carry and wrap
        pulse_clear();
        chk("clr_count", {tens4, ones4}, 8'h00);
        do_load(4'd0, 4'd9);
        chk("ld_09", {step1, 3'd0, tens1, ones1} , {1'b0, 3'd0, 8'h09});
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("d1_carry", {tens1, ones1}, 8'h10);
        chk("d1_carry_step", {7'd0, step1}, 8'h01);
        lim_tens = 4'd5; lim_ones = 4'd0;
        do_load(4'd9, 4'd9);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("d1_wrap_up", {tens1, ones1}, 8'h00);
        chk("d1_wrap_nodone", {6'd0, running1, done1}, 8'h02);

        // Down count to limit 97
        dir = 1'b0; lim_tens = 4'd9; lim_ones = 4'd7;
        do_load(4'd0, 4'd0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("dn_99", {tens1, ones1}, 8'h99);
        tick();
        chk("dn_98", {tens1, ones1}, 8'h98);
        tick();
        chk("dn_97", {tens1, ones1}, 8'h97);
        chk("dn_done", {6'd0, running1, done1}, 8'h01);
        tick(10);
        chk("dn_hold", {tens1, ones1}, 8'h97);
        chk("dn_hold_flags", {5'd0, running1, done1, step1}, 8'h02);

        // Restart from DONE going down reloads 99
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_99", {tens1, ones1}, 8'h99);
        chk("restart_flags", {5'd0, running1, done1, step1}, 8'h04);

        // Entering RUN already at the limit must not end the run
        do_load(4'd9, 4'd7);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("at_lim_start", {tens1, ones1}, 8'h96);
        chk("at_lim_flags", {6'd0, running1, done1}, 8'h02);

        // Pause keeps the partial prescaler interval
        dir = 1'b1; lim_tens = 4'd9; lim_ones = 4'd9;
        pulse_clear();
        start = 1'b1; tick(); start = 1'b0;
        tick(2);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("pause_state", {3'd0, running4, ones4}, 8'h00);
        tick(10);
        chk("pause_hold", {tens4, ones4}, 8'h00);
        start = 1'b1; tick(); start = 1'b0;
        chk("resume_run", {3'd0, running4, ones4}, 8'h10);
        tick();
        chk("resume_early", {tens4, ones4}, 8'h00);
        tick();
        chk("resume_step", {step4, 3'd0, ones4}, 8'h81);

        // Priority: clear beats load and start
        load_tens = 4'd5; load_ones = 4'd5;
        clear = 1'b1; load = 1'b1; start = 1'b1; tick();
        clear = 1'b0; load = 1'b0; start = 1'b0;
        chk("prio_count", {tens1, ones1}, 8'h00);
        chk("prio_idle", {5'd0, running1, done1, step1}, 8'h00);
        do_load(4'd3, 4'd12);
        chk("clamp_ones", {tens1, ones1}, 8'h39);

`ifdef BCD_COUNT_CTRL_LAP_EN
        do_load(4'd0, 4'd3);
        start = 1'b1; tick(); start = 1'b0;
        lap = 1'b1; tick(); lap = 1'b0;
        chk("lap_value", {lap_tens1, lap_ones1}, 8'h03);
        chk("lap_count", {tens1, ones1}, 8'h04);
        pulse_clear();
        chk("lap_clear", {lap_tens1, lap_ones1}, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
